// File: rtl/pipe_pkg.sv
// Shared SimpleRISC pipeline definitions.
// Register-file geometry, NOP encoding and scoreboard entry layout.
package pipe_pkg;

  localparam int          REG_W    = 4;
  localparam int          NUM_REGS = 16;
  localparam logic [3:0]  RA_REG   = 4'd15;
  localparam logic [31:0] NOP      = 32'h6800_0000;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (E, M, RW) with
// RAW match against the decode-stage sources.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  sb_entry_t        push_i,
  input  logic [REG_W-1:0] src1_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  output logic             raw_o
);

  sb_entry_t sb_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  always_comb begin
    raw_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_q[i].valid &&
          ((use1_i && (src1_i == sb_q[i].rd)) ||
           (use2_i && (src2_i == sb_q[i].rd)))) begin
        raw_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_interlock_ctrl.sv
// Decode interlock: RAW stall, branch squash and
// saturating debug counters for stall/flush activity.
module hazard_interlock_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1_D,
  input  logic [REG_W-1:0] src2_D,
  input  logic             use1_D,
  input  logic             use2_D,
  input  logic [REG_W-1:0] dst_D,
  input  logic             iswb_D_hazard,
  input  logic             isbranch_taken_E,
  output logic             add_stall,
  output logic             hold_F,
  output logic             flush_FD,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  logic             raw;
  logic             issue;
  sb_entry_t        push;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  hazard_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .src1_i (src1_D),
    .src2_i (src2_D),
    .use1_i (use1_D),
    .use2_i (use2_D),
    .raw_o  (raw)
  );

  // Branch squash outranks the RAW stall.
  always_comb begin
    add_stall = 1'b0;
    hold_F    = 1'b0;
    flush_FD  = 1'b0;
    if (isbranch_taken_E) begin
      flush_FD = 1'b1;
    end else if (raw) begin
      add_stall = 1'b1;
      hold_F    = 1'b1;
    end
  end

  assign issue = !add_stall && !isbranch_taken_E;

  always_comb begin
    push = '0;
    if (issue) begin
      push.valid = iswb_D_hazard;
      push.rd    = dst_D;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (add_stall && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (isbranch_taken_E && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
// Bench for hazard_interlock_ctrl: vector table with
// an expectation queue, plus reset and saturation sequences.
module tb_hazard_interlock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1_D, src2_D, dst_D;
  logic        use1_D, use2_D, iswb_D_hazard, isbranch_taken_E;
  logic        add_stall, hold_F, flush_FD;
  logic [15:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  hazard_interlock_ctrl #(
    .DEPTH (3),
    .CNT_W (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src1_D           (src1_D),
    .src2_D           (src2_D),
    .use1_D           (use1_D),
    .use2_D           (use2_D),
    .dst_D            (dst_D),
    .iswb_D_hazard    (iswb_D_hazard),
    .isbranch_taken_E (isbranch_taken_E),
    .add_stall        (add_stall),
    .hold_F           (hold_F),
    .flush_FD         (flush_FD),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2, d;
    logic       u1, u2, wb, br;
    logic       st, hd, fl;
  } vec_t;

  typedef struct {
    logic        st, hd, fl;
    logic [15:0] sc, fc;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  logic [15:0] m_sc, m_fc;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic add(input logic [3:0] s1, s2,
                     input logic u1, u2,
                     input logic [3:0] d,
                     input logic wb, br, st, hd, fl);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
    v.d = d; v.wb = wb; v.br = br;
    v.st = st; v.hd = hd; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input logic [3:0] s1, s2,
                       input logic u1, u2,
                       input logic [3:0] d,
                       input logic wb, br);
    src1_D = s1; src2_D = s2; use1_D = u1; use2_D = u2;
    dst_D = d; iswb_D_hazard = wb; isbranch_taken_E = br;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    chk("reset_stall", {15'd0, add_stall}, 16'd0);
    chk("reset_hold", {15'd0, hold_F}, 16'd0);
    chk("reset_flush", {15'd0, flush_FD}, 16'd0);
    chk("reset_scnt", stall_cycles, 16'd0);
    chk("reset_fcnt", flush_events, 16'd0);
    #10 rst = 1'b1;

    // dependent pair
    add(2, 3, 1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 5, 1, 1, 4, 1, 0, 1, 1, 0);
    add(1, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    nops(3);
    // distance 2
    add(0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    add(7, 8, 1, 1, 6, 1, 0, 0, 0, 0);
    add(2, 0, 1, 0, 9, 1, 0, 1, 1, 0);
    add(2, 0, 1, 0, 9, 1, 0, 1, 1, 0);
    add(2, 0, 1, 0, 9, 1, 0, 0, 0, 0);
    nops(3);
    // distance 4
    add(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    add(11, 12, 1, 1, 10, 1, 0, 0, 0, 0);
    add(12, 13, 1, 1, 11, 1, 0, 0, 0, 0);
    add(13, 14, 1, 1, 12, 1, 0, 0, 0, 0);
    add(3, 3, 1, 1, 8, 1, 0, 0, 0, 0);
    nops(3);
    // immediate form and non-writing store
    add(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    add(9, 5, 1, 0, 9, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    add(7, 7, 1, 1, 6, 1, 0, 0, 0, 0);
    nops(3);
    // call then ret on ra
    add(0, 0, 0, 0, 15, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(15, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add(15, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nops(3);
    // branch during stall, then lone branch
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 4, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 4, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    nops(3);
    // two producers of r1
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 1, 0, 4, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 4, 1, 0, 0, 0, 0);
    nops(3);

    m_sc = 0;
    m_fc = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      v = vecs[k];
      drive(v.s1, v.s2, v.u1, v.u2, v.d, v.wb, v.br);
      e.st = v.st; e.hd = v.hd; e.fl = v.fl;
      e.sc = m_sc; e.fc = m_fc;
      expq.push_back(e);
      if (v.st) m_sc = m_sc + 16'd1;
      if (v.br) m_fc = m_fc + 16'd1;
      @(negedge clk);
      e = expq.pop_front();
      if (add_stall !== e.st || hold_F !== e.hd ||
          flush_FD !== e.fl) begin
        errors++;
        $display("FAIL vec%0d: stall/hold/flush=%b%b%b expected %b%b%b",
                 k, add_stall, hold_F, flush_FD, e.st, e.hd, e.fl);
      end
      checks++;
      chk($sformatf("vec%0d_scnt", k), stall_cycles, e.sc);
      chk($sformatf("vec%0d_fcnt", k), flush_events, e.fc);
    end
    @(negedge clk);
    chk("total_scnt", stall_cycles, 16'd12);
    chk("total_fcnt", flush_events, 16'd2);

    // async reset in the middle of a stall
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive(1, 0, 1, 0, 4, 1, 0);
    @(negedge clk);
    chk("pre_rst_stall", {15'd0, add_stall}, 16'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_stall", {15'd0, add_stall}, 16'd0);
    chk("midrst_hold", {15'd0, hold_F}, 16'd0);
    chk("midrst_scnt", stall_cycles, 16'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", {15'd0, add_stall}, 16'd0);
    @(negedge clk);
    chk("post_rst_scnt", stall_cycles, 16'd0);
    chk("post_rst_fcnt", flush_events, 16'd0);

    // saturation: self-dependent chain stalls 3 of every 4 cycles
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    drive(1, 0, 1, 0, 1, 1, 0);
    repeat (87379) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", stall_cycles, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", stall_cycles, 16'hFFFF);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", stall_cycles, 16'hFFFF);
    chk("sat_fcnt", flush_events, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
